// File: rtl/i2s_rx.sv
// I2S receiver for a PCM1808-style ADC: oversamples BCLK/LRCLK/SDATA on MCLK,
// deserialises left/right words and presents them as a valid/ready stereo pair.
module i2s_rx #(
    parameter int DATA_W     = 24,
    parameter int SLOT_BCLKS = 32
) (
    input  logic              mclk_i,
    input  logic              rst_n_i,
    input  logic              devices_ready_i,
    input  logic              bclk_i,
    input  logic              lrclk_i,
    input  logic              sdata_i,
    output logic [DATA_W-1:0] left_o,
    output logic [DATA_W-1:0] right_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              overrun_o,
    output logic              frame_err_o,
    input  logic              clear_i
);

    localparam int IDX_W = $clog2(SLOT_BCLKS + 1);
    localparam logic [IDX_W-1:0] SLOT_IDX = IDX_W'(SLOT_BCLKS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W);

    typedef enum logic [1:0] {IDLE, SYNC, LEFT, RIGHT} state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic [DATA_W-1:0] lword_q, lword_d;
    logic [DATA_W-1:0] left_q, left_d, right_q, right_d;
    logic              valid_q, valid_d, ovr_q, ovr_d, ferr_q, ferr_d;
    logic              bclk_s1_q, bclk_s2_q, lr_s1_q, lr_s2_q, sd_s1_q;
    logic              rise, lr_edge, lr_fall, capture, complete, ovr_set, ferr_set;

    assign rise    = bclk_s1_q & ~bclk_s2_q;
    assign lr_edge = lr_s1_q ^ lr_s2_q;
    assign lr_fall = ~lr_s1_q & lr_s2_q;
    // Index 0 is the previous word's trailing bit; indices past DATA_W are padding.
    assign capture = rise && !lr_edge && (idx_q != '0) && (idx_q <= LAST_IDX);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        sh_d     = sh_q;
        lword_d  = lword_q;
        left_d   = left_q;
        right_d  = right_q;
        valid_d  = valid_q;
        complete = 1'b0;
        ovr_set  = 1'b0;
        ferr_set = 1'b0;

        if (valid_q && ready_i) valid_d = 1'b0;

        if (!devices_ready_i) begin
            state_d = IDLE;
            idx_d   = '0;
            sh_d    = '0;
            lword_d = '0;
        end else begin
            if (lr_edge) idx_d = '0;
            else if (rise && idx_q != SLOT_IDX) idx_d = idx_q + 1'b1;

            unique case (state_q)
                IDLE: state_d = SYNC;
                SYNC: if (lr_fall) state_d = LEFT;
                LEFT, RIGHT: begin
                    if (capture) sh_d = {sh_q[DATA_W-2:0], sd_s1_q};
                    complete = capture && (state_q == RIGHT) && (idx_q == LAST_IDX);
                    if (lr_edge) begin
                        if (idx_q != SLOT_IDX) begin
                            ferr_set = 1'b1;
                            state_d  = SYNC;
                        end else if (state_q == LEFT) begin
                            state_d = RIGHT;
                            lword_d = sh_q;
                        end else begin
                            state_d = LEFT;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // A completion may reload in the same cycle the consumer takes the old pair.
        if (complete) begin
            if (!valid_q || ready_i) begin
                left_d  = lword_q;
                right_d = {sh_q[DATA_W-2:0], sd_s1_q};
                valid_d = 1'b1;
            end else begin
                ovr_set = 1'b1;
            end
        end

        ovr_d  = ovr_set  | (ovr_q  & ~clear_i);
        ferr_d = ferr_set | (ferr_q & ~clear_i);
    end

    always_ff @(posedge mclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            sh_q      <= '0;
            lword_q   <= '0;
            left_q    <= '0;
            right_q   <= '0;
            valid_q   <= 1'b0;
            ovr_q     <= 1'b0;
            ferr_q    <= 1'b0;
            bclk_s1_q <= 1'b0;
            bclk_s2_q <= 1'b0;
            lr_s1_q   <= 1'b0;
            lr_s2_q   <= 1'b0;
            sd_s1_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            sh_q      <= sh_d;
            lword_q   <= lword_d;
            left_q    <= left_d;
            right_q   <= right_d;
            valid_q   <= valid_d;
            ovr_q     <= ovr_d;
            ferr_q    <= ferr_d;
            bclk_s1_q <= bclk_i;
            bclk_s2_q <= bclk_s1_q;
            lr_s1_q   <= lrclk_i;
            lr_s2_q   <= lr_s1_q;
            sd_s1_q   <= sdata_i;
        end
    end

    assign left_o      = left_q;
    assign right_o     = right_q;
    assign valid_o     = valid_q;
    assign overrun_o   = ovr_q;
    assign frame_err_o = ferr_q;

endmodule
